// File: rtl/countdown_timer.sv
// Minutes:seconds countdown timer with centisecond resolution, debounced active-low
// buttons and six active-low seven-segment digits; raises Expired at 00:00.00.
module countdown_timer #(
  parameter int TICK_DIV  = 500000,
  parameter int DB_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        hold,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [6:0]  Hex1,
  output logic [6:0]  Hex2,
  output logic [6:0]  Hex3,
  output logic [6:0]  Hex4,
  output logic [6:0]  Hex5,
  output logic [6:0]  Hex6,
  output logic        CLK_ind,
  output logic        Expired,
  output logic        Running
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [TDW-1:0] TICK_LAST = TDW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_EXPIRED} state_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_d);
    return (d > max_d) ? max_d : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Button bit order: [0] start_stop, [1] hold, [2] load
  logic [2:0]     raw_s, sync1_r, sync2_r, db_r;
  logic [1:0]     db_prev_r, ev_r;
  logic [DBW-1:0] db_cnt_r [3];

  state_t         state_r, state_s;
  logic [3:0]     min_t_r, min_o_r, sec_t_r, sec_o_r, cs_t_r, cs_o_r;
  logic [3:0]     min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s;
  logic [TDW-1:0] div_r;
  logic [5:0]     blink_r;
  logic           start_ev_s, load_ev_s, do_load_s, count_en_s, tick_s;
  logic           count_zero_s, last_cs_s;

  assign raw_s        = {load, hold, start_stop};
  assign start_ev_s   = ev_r[0];
  assign load_ev_s    = ev_r[1];
  assign do_load_s    = load_ev_s && (state_r != S_RUN);
  assign count_en_s   = (state_r == S_RUN) && db_r[1];
  assign tick_s       = count_en_s && (div_r == TICK_LAST);
  assign count_zero_s = ({min_t_r, min_o_r, sec_t_r, sec_o_r, cs_t_r, cs_o_r} == 24'h000000);
  assign last_cs_s    = ({min_t_r, min_o_r, sec_t_r, sec_o_r, cs_t_r, cs_o_r} == 24'h000001);

  // Synchronise, debounce and edge-detect the three buttons
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_r   <= 3'b111;
      sync2_r   <= 3'b111;
      db_r      <= 3'b111;
      db_prev_r <= 2'b11;
      ev_r      <= 2'b00;
      for (int i = 0; i < 3; i++) db_cnt_r[i] <= {DBW{1'b0}};
    end else begin
      sync1_r   <= raw_s;
      sync2_r   <= sync1_r;
      db_prev_r <= {db_r[2], db_r[0]};
      ev_r      <= db_prev_r & ~{db_r[2], db_r[0]};
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            db_r[i]     <= sync2_r[i];
            db_cnt_r[i] <= {DBW{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DBW'(1);
          end
        end else begin
          db_cnt_r[i] <= {DBW{1'b0}};
        end
      end
    end
  end

  // Count minus one centisecond, borrowing through the BCD digits
  always_comb begin
    min_t_s = min_t_r;
    min_o_s = min_o_r;
    sec_t_s = sec_t_r;
    sec_o_s = sec_o_r;
    cs_t_s  = cs_t_r;
    cs_o_s  = cs_o_r;
    if (cs_o_r != 4'd0) begin
      cs_o_s = cs_o_r - 4'd1;
    end else begin
      cs_o_s = 4'd9;
      if (cs_t_r != 4'd0) begin
        cs_t_s = cs_t_r - 4'd1;
      end else begin
        cs_t_s = 4'd9;
        if (sec_o_r != 4'd0) begin
          sec_o_s = sec_o_r - 4'd1;
        end else begin
          sec_o_s = 4'd9;
          if (sec_t_r != 4'd0) begin
            sec_t_s = sec_t_r - 4'd1;
          end else begin
            sec_t_s = 4'd5;
            if (min_o_r != 4'd0) begin
              min_o_s = min_o_r - 4'd1;
            end else begin
              min_o_s = 4'd9;
              min_t_s = min_t_r - 4'd1;
            end
          end
        end
      end
    end
  end

  // Next-state logic; expiry outranks a coincident start_stop press
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (do_load_s) state_s = S_IDLE;
        else if (start_ev_s && !count_zero_s) state_s = S_RUN;
        else state_s = S_IDLE;
      end
      S_RUN: begin
        if (tick_s && last_cs_s) state_s = S_EXPIRED;
        else if (start_ev_s) state_s = S_STOP;
        else state_s = S_RUN;
      end
      S_STOP: begin
        if (do_load_s) state_s = S_IDLE;
        else if (start_ev_s) state_s = S_RUN;
        else state_s = S_STOP;
      end
      S_EXPIRED: begin
        if (do_load_s) state_s = S_IDLE;
        else state_s = S_EXPIRED;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register with status flags aligned to it
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      Running <= 1'b0;
      Expired <= 1'b0;
    end else begin
      state_r <= state_s;
      Running <= (state_s == S_RUN);
      Expired <= (state_s == S_EXPIRED);
    end
  end

  // Count, tick divider and blink; divider holds its phase while not counting
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      {min_t_r, min_o_r, sec_t_r, sec_o_r, cs_t_r, cs_o_r} <= 24'h000000;
      div_r   <= {TDW{1'b0}};
      blink_r <= 6'd0;
      CLK_ind <= 1'b0;
    end else if (do_load_s) begin
      min_t_r <= clamp_digit(preset[15:12], 4'd9);
      min_o_r <= clamp_digit(preset[11:8], 4'd9);
      sec_t_r <= clamp_digit(preset[7:4], 4'd5);
      sec_o_r <= clamp_digit(preset[3:0], 4'd9);
      cs_t_r  <= 4'd0;
      cs_o_r  <= 4'd0;
      div_r   <= {TDW{1'b0}};
      blink_r <= 6'd0;
      CLK_ind <= 1'b0;
    end else if (tick_s) begin
      {min_t_r, min_o_r, sec_t_r, sec_o_r, cs_t_r, cs_o_r} <=
        {min_t_s, min_o_s, sec_t_s, sec_o_s, cs_t_s, cs_o_s};
      div_r <= {TDW{1'b0}};
      if (last_cs_s) begin
        blink_r <= 6'd0;
        CLK_ind <= 1'b0;
      end else if (blink_r == 6'd49) begin
        blink_r <= 6'd0;
        CLK_ind <= ~CLK_ind;
      end else begin
        blink_r <= blink_r + 6'd1;
      end
    end else if (count_en_s) begin
      div_r <= div_r + TDW'(1);
    end else begin
      div_r <= div_r;
    end
  end

  assign Hex1 = seg7(min_t_r);
  assign Hex2 = seg7(min_o_r);
  assign Hex3 = seg7(sec_t_r);
  assign Hex4 = seg7(sec_o_r);
  assign Hex5 = seg7(cs_t_r);
  assign Hex6 = seg7(cs_o_r);
endmodule
